// File: rtl/serial_bill_sub_ctrl.sv
// Bit-serial subtractor: a - b computed LSB first through one full-subtractor cell,
// with a start/busy/done handshake; result and final borrow are held between runs.
module serial_bill_sub_ctrl #(
  parameter int unsigned WIDTH = 13
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] a_in,
  input  logic [WIDTH-1:0] b_in,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] diff_out,
  output logic             borrow_out
);

  localparam int unsigned CW = (WIDTH > 2) ? $clog2(WIDTH) : 1;
  localparam logic [CW-1:0] LAST_BIT = CW'(WIDTH - 1);

  typedef enum logic {
    IDLE,
    RUN
  } state_t;

  state_t           state, state_nx;
  logic [WIDTH-1:0] a_sh, b_sh, res;
  logic [CW-1:0]    cnt;
  logic             brw;
  logic             accept, last;
  logic             abit, bbit, dbit, bo;

  // Single full-subtractor cell shared by every bit position.
  assign abit = a_sh[0];
  assign bbit = b_sh[0];
  assign dbit = abit ^ bbit ^ brw;
  assign bo   = (~abit & bbit) | (~(abit ^ bbit) & brw);

  assign busy = (state == RUN);

  always_comb begin
    state_nx = state;
    accept   = 1'b0;
    last     = 1'b0;
    case (state)
      IDLE: begin
        if (start) begin
          accept   = 1'b1;
          state_nx = RUN;
        end
      end
      RUN: begin
        if (cnt == LAST_BIT) begin
          last     = 1'b1;
          state_nx = IDLE;
        end
      end
      default: state_nx = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_nx;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      a_sh       <= '0;
      b_sh       <= '0;
      res        <= '0;
      cnt        <= '0;
      brw        <= 1'b0;
      done       <= 1'b0;
      diff_out   <= '0;
      borrow_out <= 1'b0;
    end else begin
      done <= last;
      if (accept) begin
        a_sh <= a_in;
        b_sh <= b_in;
        res  <= '0;
        cnt  <= '0;
        brw  <= 1'b0;
      end else if (state == RUN) begin
        a_sh <= {1'b0, a_sh[WIDTH-1:1]};
        b_sh <= {1'b0, b_sh[WIDTH-1:1]};
        res  <= {dbit, res[WIDTH-1:1]};
        cnt  <= cnt + 1'b1;
        brw  <= bo;
      end
      // The MSB difference bit is still combinational on the completing edge.
      if (last) begin
        diff_out   <= {dbit, res[WIDTH-1:1]};
        borrow_out <= bo;
      end
    end
  end

endmodule

// File: tb/tb_serial_bill_sub_ctrl.sv
// Directed self-checking bench for serial_bill_sub_ctrl (WIDTH = 13).
`timescale 1ns/1ps
module tb_serial_bill_sub_ctrl;

  localparam int unsigned W = 13;

  logic         clk = 1'b0;
  logic         rst;
  logic         start;
  logic [W-1:0] a_in, b_in;
  logic         busy, done, borrow_out;
  logic [W-1:0] diff_out;

  int unsigned n_tests = 0;
  int unsigned n_fail  = 0;

  // Expected held outputs, tracked by the bench across operations.
  logic [W-1:0] hold_d;
  logic         hold_b;

  serial_bill_sub_ctrl #(.WIDTH(W)) dut (
    .clk        (clk),
    .rst        (rst),
    .start      (start),
    .a_in       (a_in),
    .b_in       (b_in),
    .busy       (busy),
    .done       (done),
    .diff_out   (diff_out),
    .borrow_out (borrow_out)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // One full operation; optional stray start pulses while busy.
  task automatic run_op(input logic [W-1:0] a, input logic [W-1:0] b,
                        input logic [W-1:0] exp_d, input logic exp_b, input logic noise);
    a_in  = a;
    b_in  = b;
    start = 1'b1;
    tick();
    start = 1'b0;
    a_in  = ~a;
    b_in  = a ^ 13'h1555;
    check("busy_after_start", busy, 1);
    for (int k = 1; k <= 13; k++) begin
      if (noise && (k == 3 || k == 12)) begin
        start = 1'b1;
        a_in  = 13'd4000;
        b_in  = 13'd17;
      end else begin
        start = 1'b0;
      end
      tick();
      if (k < 13) begin
        check("run_busy", busy, 1);
        check("run_done", done, 0);
        check("run_diff_hold", diff_out, hold_d);
        check("run_borrow_hold", borrow_out, hold_b);
      end
    end
    start = 1'b0;
    check("end_busy", busy, 0);
    check("end_done", done, 1);
    check("end_diff", diff_out, exp_d);
    check("end_borrow", borrow_out, exp_b);
    hold_d = exp_d;
    hold_b = exp_b;
    tick();
    check("post_done", done, 0);
    check("post_busy", busy, 0);
    check("post_diff", diff_out, hold_d);
  endtask

  initial begin
    rst   = 1'b1;
    start = 1'b0;
    a_in  = '0;
    b_in  = '0;
    hold_d = '0;
    hold_b = 1'b0;
    tick();
    tick();
    check("rst_busy", busy, 0);
    check("rst_done", done, 0);
    check("rst_diff", diff_out, 0);
    check("rst_borrow", borrow_out, 0);
    rst = 1'b0;
    tick();
    check("idle_busy", busy, 0);

    // Basic subtractions, including wrap-around and operand extremes.
    run_op(13'd1000, 13'd250,  13'd750,  1'b0, 1'b0);
    run_op(13'd250,  13'd1000, 13'd7442, 1'b1, 1'b0);
    run_op(13'd0,    13'd1,    13'd8191, 1'b1, 1'b0);
    run_op(13'd8191, 13'd8191, 13'd0,    1'b0, 1'b0);
    run_op(13'd4096, 13'd1,    13'd4095, 1'b0, 1'b0);
    run_op(13'd1,    13'd8191, 13'd2,    1'b1, 1'b0);

    // Stray start pulses while busy must be ignored.
    run_op(13'd1000, 13'd250,  13'd750,  1'b0, 1'b1);

    // Start held high through done: back-to-back operations.
    a_in  = 13'd500;
    b_in  = 13'd499;
    start = 1'b1;
    tick();
    a_in  = 13'd9;
    b_in  = 13'd10;
    for (int k = 1; k <= 12; k++) begin
      tick();
      check("b2b_first_nodone", done, 0);
    end
    tick();
    check("b2b_first_done", done, 1);
    check("b2b_first_diff", diff_out, 1);
    check("b2b_first_borrow", borrow_out, 0);
    check("b2b_first_busy", busy, 0);
    for (int k = 1; k <= 13; k++) begin
      tick();
      check("b2b_second_nodone", done, 0);
      check("b2b_second_busy", busy, 1);
      check("b2b_second_hold", diff_out, 1);
    end
    tick();
    start = 1'b0;
    check("b2b_second_done", done, 1);
    check("b2b_second_diff", diff_out, 8191);
    check("b2b_second_borrow", borrow_out, 1);
    tick();
    check("b2b_after_done", done, 0);
    check("b2b_after_busy", busy, 0);
    hold_d = 13'd8191;
    hold_b = 1'b1;

    // Reset in the middle of a run aborts it without a done pulse.
    a_in  = 13'd1000;
    b_in  = 13'd250;
    start = 1'b1;
    tick();
    start = 1'b0;
    for (int k = 1; k <= 6; k++) tick();
    check("abort_busy_before", busy, 1);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    check("abort_busy", busy, 0);
    check("abort_done", done, 0);
    check("abort_diff", diff_out, 0);
    check("abort_borrow", borrow_out, 0);
    hold_d = '0;
    hold_b = 1'b0;
    for (int k = 1; k <= 10; k++) begin
      tick();
      check("abort_no_done", done, 0);
    end
    run_op(13'd1000, 13'd250, 13'd750, 1'b0, 1'b0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
